reg_writeback_ctrl: RTL and testbench
=====================================

Name: reg_writeback_ctrl

Overview:
Writer-side controller for the single-write-port MIPS register file. It accepts writeback results from the ALU and memory paths, up to two per cycle, and buffers them in an in-order pending-write queue. It drains one write per cycle onto the register file's RegW/DR/Reg_In port. It also provides a bypass lookup so decode can read values that are not yet committed.

Parameters:
DATA_W, 32, width of a register value
ADDR_W, 5, register index width
DEPTH, 4, pending-write queue entries (power of 2, >=4)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_n  in  1  synchronous reset, active low
MEM_Valid  in  1  memory-path writeback request (older instruction)
MEM_DR  in  ADDR_W  memory-path destination register
MEM_Data  in  DATA_W  memory-path data
ALU_Valid  in  1  ALU-path writeback request (younger instruction)
ALU_DR  in  ADDR_W  ALU-path destination register
ALU_Data  in  DATA_W  ALU-path data
Stall  out  1  queue cannot guarantee two free slots; producers must hold
RegW  out  1  register-file write enable (registered)
DR  out  ADDR_W  register-file write index (registered)
Reg_In  out  DATA_W  register-file write data (registered)
Q_SR  in  ADDR_W  bypass query register index
Q_Hit  out  1  a pending or in-flight write targets Q_SR
Q_Data  out  DATA_W  youngest pending value for Q_SR; 0 when no hit
Empty  out  1  queue empty and RegW low

Behaviour:
- Reset: when RST_n=0 at an edge, set count, read pointer and write pointer to 0; RegW=0, DR=0, Reg_In=0. Pending writes are discarded, including a reset arriving mid-drain. Queue storage contents are don't-care. After reset: Stall=0, Empty=1, Q_Hit=0.
- Stall = (count > DEPTH-2), combinational from the current count.
- When Stall=1, both Valid inputs are ignored (not enqueued). Producers hold their requests.
- Enqueue, when Stall=0:
  - A valid request whose DR is 0 is dropped, because $0 is hardwired.
  - Remaining requests are written at the tail in order: MEM first, then ALU. Both can be written in the same cycle (0, 1 or 2 entries).
- Dequeue: when count>0 at an edge, the head entry moves into the output register: RegW<=1, DR<=head DR, Reg_In<=head data. The read pointer advances.
- When count=0 at an edge: RegW<=0. DR and Reg_In hold their values.
- Count: count_next = count + enq_n - deq. Enqueue and dequeue in the same cycle are legal.
- Pointers wrap modulo DEPTH.
- There is no cut-through. A request sampled at edge k sits at the head no earlier than cycle k. RegW is high no earlier than the cycle after edge k+1, so minimum latency is 2 edges.
- Commit rate: at most one write per cycle.
- Commit order: strictly program order (MEM before ALU within a cycle, earlier cycles first). Repeated writes to the same DR all commit in order, with no coalescing.
- Bypass (combinational on Q_SR and current state):
  - Search all valid queue entries from youngest (tail-1) to oldest.
  - Then search the output register, which counts only when RegW=1. It must be included because the register file commits at the edge, and a same-edge registered read returns the old value.
  - The first match sets Q_Hit=1 and Q_Data = that entry's data.
  - Q_SR=0 never hits.
  - Same-cycle incoming requests are not searched.
- Empty = (count==0) && !RegW.

Test Plan:
- Single write: reset, then ALU_Valid=1, ALU_DR=5, ALU_Data=0x1234 for one cycle -> two edges later RegW=1, DR=5, Reg_In=0x1234 for exactly one cycle, then Empty=1.
- Dual issue, same target: MEM (DR=7, 0xAAAA) and ALU (DR=7, 0xBBBB) in one cycle -> RegW high on two consecutive cycles, first 0xAAAA then 0xBBBB. Meanwhile, Q_SR=7 returns 0xBBBB while that entry is pending and 0xAAAA is also queued.
- Backpressure (DEPTH=4): dual requests on consecutive cycles -> Stall rises once count reaches 3. Requests offered during Stall are not enqueued. The drain commits every accepted write once, in order, with no loss.
- $0 filter: MEM DR=0 and ALU DR=3 together -> only DR=3 is committed. Q_SR=0 gives Q_Hit=0 throughout.
- In-flight bypass: a write to DR=9 drains and RegW=1 with DR=9 -> Q_SR=9 gives Q_Hit=1 with that data during the RegW cycle, and Q_Hit=0 on the next cycle.
- Reset mid-operation: with 3 entries pending, drive RST_n=0 for one edge -> RegW=0, Empty=1 and Stall=0 on the next cycle. No dropped entry is ever written.

Source files
------------

// File: rtl/reg_writeback_ctrl_if.sv
// reg_writeback_ctrl_if: producer, register-file and bypass signals of the writeback controller
interface reg_writeback_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              MEM_Valid;
    logic [ADDR_W-1:0] MEM_DR;
    logic [DATA_W-1:0] MEM_Data;
    logic              ALU_Valid;
    logic [ADDR_W-1:0] ALU_DR;
    logic [DATA_W-1:0] ALU_Data;
    logic              Stall;
    logic              RegW;
    logic [ADDR_W-1:0] DR;
    logic [DATA_W-1:0] Reg_In;
    logic [ADDR_W-1:0] Q_SR;
    logic              Q_Hit;
    logic [DATA_W-1:0] Q_Data;
    logic              Empty;

    modport master (
        output MEM_Valid, MEM_DR, MEM_Data, ALU_Valid, ALU_DR, ALU_Data, Q_SR,
        input  Stall, RegW, DR, Reg_In, Q_Hit, Q_Data, Empty
    );

    modport slave (
        input  MEM_Valid, MEM_DR, MEM_Data, ALU_Valid, ALU_DR, ALU_Data, Q_SR,
        output Stall, RegW, DR, Reg_In, Q_Hit, Q_Data, Empty
    );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: in-order pending-write queue draining one register-file write per cycle, with bypass lookup
module reg_writeback_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input logic                CLK,
    input logic                RST_n,
    reg_writeback_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] dr_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr, alu_slot, idx;
    logic [CW-1:0]     count;
    logic              mem_en, alu_en, hit;
    logic [DATA_W-1:0] hit_data;

    // Keep two slots free so a dual issue can always be absorbed; $0 writes are dropped
    assign bus.Stall = count > CW'(DEPTH - 2);
    assign mem_en    = !bus.Stall && bus.MEM_Valid && bus.MEM_DR != '0;
    assign alu_en    = !bus.Stall && bus.ALU_Valid && bus.ALU_DR != '0;
    assign alu_slot  = wr_ptr + PW'(mem_en);
    assign bus.Empty = count == '0 && !bus.RegW;

    // Queue storage: MEM (older) lands at the tail, ALU right behind it
    always_ff @(posedge CLK) begin
        if (mem_en) begin
            dr_q[wr_ptr]   <= bus.MEM_DR;
            data_q[wr_ptr] <= bus.MEM_Data;
        end
        if (alu_en) begin
            dr_q[alu_slot]   <= bus.ALU_DR;
            data_q[alu_slot] <= bus.ALU_Data;
        end
    end

    // Pointers, occupancy and the registered register-file write port
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            bus.RegW   <= 1'b0;
            bus.DR     <= '0;
            bus.Reg_In <= '0;
        end else begin
            wr_ptr   <= wr_ptr + PW'(mem_en) + PW'(alu_en);
            count    <= count + CW'(mem_en) + CW'(alu_en) - CW'(count != '0);
            bus.RegW <= count != '0;
            if (count != '0) begin
                bus.DR     <= dr_q[rd_ptr];
                bus.Reg_In <= data_q[rd_ptr];
                rd_ptr     <= rd_ptr + PW'(1);
            end
        end
    end

    // Bypass: in-flight write first, then queue oldest to youngest so the youngest match wins
    always_comb begin
        hit      = bus.RegW && bus.DR == bus.Q_SR;
        hit_data = bus.Reg_In;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count && dr_q[idx] == bus.Q_SR) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
        bus.Q_Hit  = hit && bus.Q_SR != '0;
        bus.Q_Data = bus.Q_Hit ? hit_data : '0;
    end
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: directed checks of enqueue, drain order, backpressure, $0 filter, bypass and reset
module tb_reg_writeback_ctrl;
    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    always #5 CLK = ~CLK;

    reg_writeback_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_writeback_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
        .CLK(CLK),
        .RST_n(RST_n),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                         input logic av, input logic [4:0] ad, input logic [31:0] adat);
        bus.MEM_Valid = mv;
        bus.MEM_DR    = md;
        bus.MEM_Data  = mdat;
        bus.ALU_Valid = av;
        bus.ALU_DR    = ad;
        bus.ALU_Data  = adat;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic commit(input string tag, input logic regw, input logic [4:0] dr, input logic [31:0] d);
        chk({tag, "_regw"}, 32'(bus.RegW), 32'(regw));
        if (regw) begin
            chk({tag, "_dr"}, 32'(bus.DR), 32'(dr));
            chk({tag, "_data"}, bus.Reg_In, d);
        end
    endtask

    task automatic query(input string tag, input logic [4:0] sr, input logic h, input logic [31:0] d);
        bus.Q_SR = sr;
        #1;
        chk({tag, "_hit"}, 32'(bus.Q_Hit), 32'(h));
        chk({tag, "_qdata"}, bus.Q_Data, d);
    endtask

    initial begin
        idle();
        bus.Q_SR = 5'd0;
        step();
        step();
        chk("rst_regw", 32'(bus.RegW), 32'd0);
        chk("rst_dr", 32'(bus.DR), 32'd0);
        chk("rst_regin", bus.Reg_In, 32'd0);
        chk("rst_stall", 32'(bus.Stall), 32'd0);
        chk("rst_empty", 32'(bus.Empty), 32'd1);
        RST_n = 1'b1;

        // Single write: two edges of latency, one-cycle pulse
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
        step();
        idle();
        commit("single_e1", 1'b0, 5'd0, 32'h0);
        chk("single_e1_empty", 32'(bus.Empty), 32'd0);
        query("single_pend", 5'd5, 1'b1, 32'h1234);
        step();
        commit("single_e2", 1'b1, 5'd5, 32'h1234);
        step();
        commit("single_e3", 1'b0, 5'd0, 32'h0);
        chk("single_e3_empty", 32'(bus.Empty), 32'd1);
        chk("single_e3_dr_hold", 32'(bus.DR), 32'd5);

        // Dual issue to the same register: order kept, youngest value bypassed
        drive(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
        step();
        idle();
        query("dual_pend2", 5'd7, 1'b1, 32'hBBBB);
        step();
        commit("dual_c1", 1'b1, 5'd7, 32'hAAAA);
        query("dual_pend1", 5'd7, 1'b1, 32'hBBBB);
        step();
        commit("dual_c2", 1'b1, 5'd7, 32'hBBBB);
        query("dual_inflight", 5'd7, 1'b1, 32'hBBBB);
        step();
        commit("dual_done", 1'b0, 5'd0, 32'h0);
        chk("dual_empty", 32'(bus.Empty), 32'd1);
        query("dual_gone", 5'd7, 1'b0, 32'h0);

        // Backpressure: third dual issue arrives while stalled and is dropped
        drive(1'b1, 5'd10, 32'h1, 1'b1, 5'd11, 32'h2);
        chk("bp_stall0", 32'(bus.Stall), 32'd0);
        step();
        chk("bp_stall1", 32'(bus.Stall), 32'd0);
        drive(1'b1, 5'd12, 32'h3, 1'b1, 5'd13, 32'h4);
        step();
        chk("bp_stall2", 32'(bus.Stall), 32'd1);
        commit("bp_c1", 1'b1, 5'd10, 32'h1);
        drive(1'b1, 5'd14, 32'h5, 1'b1, 5'd15, 32'h6);
        step();
        idle();
        chk("bp_stall3", 32'(bus.Stall), 32'd0);
        commit("bp_c2", 1'b1, 5'd11, 32'h2);
        query("bp_dropped", 5'd14, 1'b0, 32'h0);
        step();
        commit("bp_c3", 1'b1, 5'd12, 32'h3);
        step();
        commit("bp_c4", 1'b1, 5'd13, 32'h4);
        step();
        commit("bp_done", 1'b0, 5'd0, 32'h0);
        chk("bp_empty", 32'(bus.Empty), 32'd1);

        // $0 filter: only the ALU write to r3 survives
        drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd3, 32'h3333);
        step();
        idle();
        query("z_q0", 5'd0, 1'b0, 32'h0);
        query("z_q3", 5'd3, 1'b1, 32'h3333);
        step();
        commit("z_c1", 1'b1, 5'd3, 32'h3333);
        query("z_q0_inflight", 5'd0, 1'b0, 32'h0);
        step();
        commit("z_done", 1'b0, 5'd0, 32'h0);
        chk("z_empty", 32'(bus.Empty), 32'd1);

        // In-flight bypass visible only during the RegW cycle
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9999);
        step();
        idle();
        step();
        commit("if_c1", 1'b1, 5'd9, 32'h9999);
        query("if_hit", 5'd9, 1'b1, 32'h9999);
        step();
        query("if_after", 5'd9, 1'b0, 32'h0);

        // Reset with three writes pending discards them all
        drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21);
        step();
        drive(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23);
        step();
        idle();
        chk("mr_stall_pre", 32'(bus.Stall), 32'd1);
        RST_n = 1'b0;
        step();
        RST_n = 1'b1;
        commit("mr_regw", 1'b0, 5'd0, 32'h0);
        chk("mr_empty", 32'(bus.Empty), 32'd1);
        chk("mr_stall", 32'(bus.Stall), 32'd0);
        query("mr_q21", 5'd21, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            commit("mr_quiet", 1'b0, 5'd0, 32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
